// File: rtl/traffic_phase_seq.sv
// Two-road phase sequencer that drives the set/reset pairs and update strobe of the lamp flip-flop bank.
// Optional pedestrian-request shortening of green is enabled by defining PED_REQ_EN.
module traffic_phase_seq #(
  parameter int TW        = 8,
  parameter int GREEN_T   = 20,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2,
  parameter int MIN_GREEN = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ew_car,
  input  logic       ped_btn,
  output logic [2:0] ns_s,
  output logic [2:0] ns_r,
  output logic [2:0] ew_s,
  output logic [2:0] ew_r,
  output logic       lamp_en,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    AR1  = 3'd0,
    NS_G = 3'd1,
    NS_Y = 3'd2,
    AR2  = 3'd3,
    EW_G = 3'd4,
    EW_Y = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt, timer_eff;
  logic          trans;
  logic          go;
  logic          upd_p0;

  function automatic logic [TW-1:0] dur(input state_t s);
    case (s)
      NS_G, EW_G: return TW'(GREEN_T);
      NS_Y, EW_Y: return TW'(YELLOW_T);
      default:    return TW'(ALLRED_T);
    endcase
  endfunction

  function automatic state_t next_state(input state_t s);
    case (s)
      AR1:     return NS_G;
      NS_G:    return NS_Y;
      NS_Y:    return AR2;
      AR2:     return EW_G;
      EW_G:    return EW_Y;
      default: return AR1;
    endcase
  endfunction

  // {ns red,yellow,green, ew red,yellow,green}
  function automatic logic [5:0] lamps(input state_t s);
    case (s)
      NS_G:    return 6'b001_100;
      NS_Y:    return 6'b010_100;
      EW_G:    return 6'b100_001;
      EW_Y:    return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction

`ifdef PED_REQ_EN
  logic pend, pend_nxt;

  // Remaining green limited to max(MIN_GREEN - elapsed, 1).
  function automatic logic [TW-1:0] clamp_rem(input logic [TW-1:0] t);
    int signed elapsed;
    int signed rem;
    elapsed = GREEN_T - int'(t);
    rem     = MIN_GREEN - elapsed;
    if (rem < 1) rem = 1;
    if (int'(t) > rem) return TW'(rem);
    return t;
  endfunction
`else
  logic unused_ped;
  assign unused_ped = ped_btn;
`endif

  always_comb begin
    timer_eff = timer;
    go        = ew_car;
`ifdef PED_REQ_EN
    if (pend && (state == NS_G || state == EW_G)) timer_eff = clamp_rem(timer);
    go = ew_car | pend;
`endif
    state_nxt = state;
    timer_nxt = timer_eff;
    trans     = 1'b0;
    if (tick) begin
      if (timer_eff == TW'(1)) begin
        if (state == NS_G && !go) begin
          timer_nxt = TW'(1);
        end else begin
          trans     = 1'b1;
          state_nxt = next_state(state);
          timer_nxt = dur(state_nxt);
        end
      end else begin
        timer_nxt = timer_eff - TW'(1);
      end
    end
`ifdef PED_REQ_EN
    pend_nxt = ped_btn | (pend & ~(trans & (state_nxt == AR1 || state_nxt == AR2)));
`endif
  end

  // Stage p0: state/lamp update; stage p1: strobe one cycle later so s/r settle first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= AR1;
      timer   <= TW'(ALLRED_T);
      ns_s    <= 3'b100;
      ew_s    <= 3'b100;
      lamp_en <= 1'b0;
      upd_p0  <= 1'b1;
`ifdef PED_REQ_EN
      pend    <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      {ns_s, ew_s} <= lamps(state_nxt);
      upd_p0       <= trans | (upd_p0 & lamp_en);
      lamp_en      <= upd_p0 & ~lamp_en;
`ifdef PED_REQ_EN
      pend         <= pend_nxt;
`endif
    end
  end

  assign ns_r  = ~ns_s;
  assign ew_r  = ~ew_s;
  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_seq.sv
// Self-checking bench for traffic_phase_seq: phase-duration table, per-cycle scoreboard and corner sequences.
module tb_traffic_phase_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       ew_car = 1'b1;
  logic       ped_btn = 1'b0;
  logic [2:0] ns_s, ns_r, ew_s, ew_r, phase;
  logic       lamp_en;

  traffic_phase_seq dut (
    .clk(clk), .reset(reset), .tick(tick), .ew_car(ew_car), .ped_btn(ped_btn),
    .ns_s(ns_s), .ns_r(ns_r), .ew_s(ew_s), .ew_r(ew_r), .lamp_en(lamp_en), .phase(phase)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int tick_cnt = 0;
  int le_cnt = 0;
  bit tick_en = 1'b0;
  bit sb_on = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Prescaler: one tick every 4 clocks when enabled
  initial begin
    int tc = 0;
    forever begin
      @(negedge clk);
      #1;
      tick = tick_en && (tc == 3);
      tc = (tc + 1) % 4;
    end
  end

  function automatic logic [5:0] mlamps(input int s);
    case (s)
      1: return 6'b001_100;
      2: return 6'b010_100;
      4: return 6'b100_001;
      5: return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction

  function automatic int mdur(input int s);
    case (s)
      1, 4: return 20;
      2, 5: return 4;
      default: return 2;
    endcase
  endfunction

  // Reference model and scoreboard
  int m_state = 0;
  int m_left = 2;
  bit m_chg = 1'b1;
  logic [9:0] sbq[$];
  logic [5:0] prev_lamps = 6'b100_100;
  logic prev_le = 1'b0;

  always @(posedge clk) begin
    logic [9:0] e, a;
    logic [2:0] inv;
    bit exp_le, changed;
    if (tick && !reset) tick_cnt++;
    if (reset) begin
      m_state = 0; m_left = 2; m_chg = 1'b1; exp_le = 1'b0;
    end else begin
      exp_le = m_chg;
      changed = 1'b0;
      if (tick) begin
        if (m_left == 1) begin
          if (!(m_state == 1 && !ew_car)) begin
            m_state = (m_state + 1) % 6;
            m_left = mdur(m_state);
            changed = 1'b1;
          end
        end else begin
          m_left--;
        end
      end
      m_chg = changed;
    end
    sbq.push_back({3'(m_state), mlamps(m_state), exp_le});
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = {phase, ns_s, ew_s, lamp_en};
      if (sb_on) check("cycle", {22'b0, a}, {22'b0, e});
    end
    inv = ~ns_s;
    check("ns_r", {29'b0, ns_r}, {29'b0, inv});
    inv = ~ew_s;
    check("ew_r", {29'b0, ew_r}, {29'b0, inv});
    check("le_double", {31'b0, lamp_en & prev_le}, 32'd0);
    if (lamp_en) begin
      le_cnt++;
      check("le_stable", {26'b0, ns_s, ew_s}, {26'b0, prev_lamps});
    end
    prev_lamps = {ns_s, ew_s};
    prev_le = lamp_en;
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_change(input logic [2:0] p, input int t0, output int nt);
    int k = 0;
    while (phase == p && k < 2000) begin cyc(); k++; end
    check("wait_change_timeout", {31'b0, phase == p}, 32'd0);
    nt = tick_cnt - t0;
  endtask

  task automatic wait_ticks(input int n);
    int t0 = tick_cnt;
    int k = 0;
    while ((tick_cnt - t0) < n && k < 2000) begin cyc(); k++; end
    check("wait_ticks_timeout", {31'b0, (tick_cnt - t0) < n}, 32'd0);
  endtask

  typedef struct {
    logic [2:0] ph;
    int         ticks;
    logic [2:0] ns;
    logic [2:0] ew;
  } row_t;

  initial begin
    row_t tbl[7];
    int t0, t1, nt, le0, le_start;
    tbl[0] = '{3'd0, 2,  3'b100, 3'b100};
    tbl[1] = '{3'd1, 20, 3'b001, 3'b100};
    tbl[2] = '{3'd2, 4,  3'b010, 3'b100};
    tbl[3] = '{3'd3, 2,  3'b100, 3'b100};
    tbl[4] = '{3'd4, 20, 3'b100, 3'b001};
    tbl[5] = '{3'd5, 4,  3'b100, 3'b010};
    tbl[6] = '{3'd0, 2,  3'b100, 3'b100};

    repeat (3) cyc();
    check("rst_phase", {29'b0, phase}, 32'd0);
    check("rst_ns_s", {29'b0, ns_s}, 32'h4);
    check("rst_ew_s", {29'b0, ew_s}, 32'h4);
    check("rst_ns_r", {29'b0, ns_r}, 32'h3);
    check("rst_lamp_en", {31'b0, lamp_en}, 32'd0);

    reset = 1'b0;
    tick_en = 1'b1;
    t0 = tick_cnt;
    cyc();
    check("le_after_release", {31'b0, lamp_en}, 32'd1);
    le_start = 0;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("row%0d_phase", i), {29'b0, phase}, {29'b0, tbl[i].ph});
      check($sformatf("row%0d_ns_s", i), {29'b0, ns_s}, {29'b0, tbl[i].ns});
      check($sformatf("row%0d_ew_s", i), {29'b0, ew_s}, {29'b0, tbl[i].ew});
      if (i == 1) le_start = le_cnt;
      if (i != 0) t0 = tick_cnt;
      wait_change(tbl[i].ph, t0, nt);
      check($sformatf("row%0d_ticks", i), nt, tbl[i].ticks);
    end
    check("wrap_phase", {29'b0, phase}, 32'd1);
    check("le_per_cycle", le_cnt - le_start, 32'd6);

    // NS rest with no side-road demand
    ew_car = 1'b0;
    wait_ticks(20);
    le0 = le_cnt;
    wait_ticks(50);
    check("rest_phase", {29'b0, phase}, 32'd1);
    check("rest_no_le", le_cnt, le0);
    ew_car = 1'b1;
    t0 = tick_cnt;
    wait_change(3'd1, t0, nt);
    check("rest_exit_ticks", nt, 32'd1);
    check("rest_exit_phase", {29'b0, phase}, 32'd2);
    cyc();
    check("rest_exit_le", {31'b0, lamp_en}, 32'd1);

    // Tick starvation in NS_Y
    tick_en = 1'b0;
    le0 = le_cnt;
    repeat (100) cyc();
    check("hold_phase", {29'b0, phase}, 32'd2);
    check("hold_ns_s", {29'b0, ns_s}, 32'h2);
    check("hold_ew_s", {29'b0, ew_s}, 32'h4);
    check("hold_no_le", le_cnt, le0);
    tick_en = 1'b1;
    t0 = tick_cnt;
    wait_change(3'd2, t0, nt);
    check("hold_ny_ticks", nt, 32'd4);

    // Reset in the middle of EW_G
    t0 = tick_cnt;
    wait_change(3'd3, t0, nt);
    check("ar2_ticks", nt, 32'd2);
    wait_ticks(5);
    check("pre_rst_phase", {29'b0, phase}, 32'd4);
    reset = 1'b1;
    #1;
    check("async_rst_ns_s", {29'b0, ns_s}, 32'h4);
    check("async_rst_ew_s", {29'b0, ew_s}, 32'h4);
    check("async_rst_phase", {29'b0, phase}, 32'd0);
    check("async_rst_le", {31'b0, lamp_en}, 32'd0);
    repeat (3) cyc();
    reset = 1'b0;
    t0 = tick_cnt;
    check("restart_phase", {29'b0, phase}, 32'd0);
    wait_change(3'd0, t0, nt);
    check("restart_ar1_ticks", nt, 32'd2);
    check("restart_next_phase", {29'b0, phase}, 32'd1);
    check("restart_ns_s", {29'b0, ns_s}, 32'h1);

`ifdef PED_REQ_EN
    // Pedestrian request two ticks into NS_G
    sb_on = 1'b0;
    t0 = tick_cnt;
    wait_ticks(2);
    ped_btn = 1'b1;
    cyc();
    ped_btn = 1'b0;
    wait_change(3'd1, t0, nt);
    check("ped_ns_g_ticks", nt, 32'd5);
    t0 = tick_cnt;
    wait_change(3'd2, t0, nt);
    t0 = tick_cnt;
    wait_change(3'd3, t0, nt);
    t1 = tick_cnt;
    wait_change(3'd4, t1, nt);
    check("ped_ew_g_full", nt, 32'd20);
`endif

    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
